// File: rtl/decode_read_stage.sv
// ARM DP/DT decode and operand-read front end: 16-entry register file with
// writeback bypass, one registered output stage with valid/ready, flush and illegal flag.
module decode_read_stage #(
  parameter int          DATA_W    = 32,
  parameter int          FWD_EN    = 1,
  parameter int unsigned PC_OFFSET = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        cond,
  output logic [3:0]        alu_op,
  output logic [5:0]        mf_op,
  output logic [3:0]        reg_d,
  output logic              s_cpsr,
  output logic              dp_dt,
  output logic              r_i,
  output logic              illegal,
  output logic [DATA_W-1:0] operand_1,
  output logic [DATA_W-1:0] operand_2,
  output logic [DATA_W-1:0] store_data
);

  logic [DATA_W-1:0] rf [16];
  logic              vld_p1;

  logic [3:0]        alu_op_p0;
  logic [5:0]        mf_op_p0;
  logic              s_cpsr_p0;
  logic              dp_dt_p0;
  logic              illegal_p0;
  logic              is_dp_p0;
  logic [DATA_W-1:0] rn_p0;
  logic [DATA_W-1:0] rm_p0;
  logic [DATA_W-1:0] rd_p0;
  logic [DATA_W-1:0] op1_p0;
  logic [DATA_W-1:0] op2_p0;
  logic [DATA_W-1:0] st_p0;
  logic              capture;

  // R15 reads see the pipelined PC; other addresses may take the same-cycle writeback.
  function automatic logic [DATA_W-1:0] read_reg(
    input logic [3:0]        addr,
    input logic [DATA_W-1:0] stored,
    input logic [DATA_W-1:0] pc,
    input logic              w_en,
    input logic [3:0]        w_addr,
    input logic [DATA_W-1:0] w_data
  );
    if (addr == 4'd15)
      return pc + DATA_W'(PC_OFFSET);
    else if ((FWD_EN != 0) && w_en && (w_addr == addr))
      return w_data;
    else
      return stored;
  endfunction

  function automatic logic [31:0] rot_imm(input logic [7:0] imm8, input logic [3:0] rot);
    logic [63:0] dbl;
    dbl = {24'd0, imm8, 24'd0, imm8} >> {rot, 1'b0};
    return dbl[31:0];
  endfunction

  function automatic logic [DATA_W-1:0] lsl(input logic [DATA_W-1:0] val, input logic [4:0] sh);
    return val << sh;
  endfunction

  assign in_ready  = !vld_p1 || out_ready;
  assign out_valid = vld_p1;
  assign capture   = in_valid && in_ready && !flush;

  // Stage p0: combinational decode and operand read
  always_comb begin
    is_dp_p0   = (inst[27:26] == 2'b00);
    dp_dt_p0   = (inst[27:26] == 2'b01);
    illegal_p0 = inst[27];
    alu_op_p0  = is_dp_p0 ? inst[24:21] : 4'd0;
    s_cpsr_p0  = is_dp_p0 ? inst[20] : 1'b0;
    mf_op_p0   = dp_dt_p0 ? inst[25:20] : 6'd0;
    rn_p0 = read_reg(inst[19:16], rf[inst[19:16]], pc_in, wb_en, wb_addr, wb_data);
    rm_p0 = read_reg(inst[3:0],   rf[inst[3:0]],   pc_in, wb_en, wb_addr, wb_data);
    rd_p0 = read_reg(inst[15:12], rf[inst[15:12]], pc_in, wb_en, wb_addr, wb_data);
    op2_p0 = '0;
    if (is_dp_p0) begin
      if (inst[25])
        op2_p0 = DATA_W'(rot_imm(inst[7:0], inst[11:8]));
      else if (!inst[4] && (inst[6:5] == 2'b00))
        op2_p0 = lsl(rm_p0, inst[11:7]);
      else
        op2_p0 = rm_p0;
    end else if (dp_dt_p0) begin
      if (inst[25])
        op2_p0 = lsl(rm_p0, inst[11:7]);
      else
        op2_p0 = DATA_W'(inst[11:0]);
    end
    op1_p0 = illegal_p0 ? '0 : rn_p0;
    st_p0  = illegal_p0 ? '0 : rd_p0;
  end

  // Stage p1: registered output bundle and register-file writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      cond       <= '0;
      alu_op     <= '0;
      mf_op      <= '0;
      reg_d      <= '0;
      s_cpsr     <= 1'b0;
      dp_dt      <= 1'b0;
      r_i        <= 1'b0;
      illegal    <= 1'b0;
      operand_1  <= '0;
      operand_2  <= '0;
      store_data <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      if (flush)
        vld_p1 <= 1'b0;
      else if (capture)
        vld_p1 <= 1'b1;
      else if (out_ready)
        vld_p1 <= 1'b0;
      if (capture) begin
        cond       <= inst[31:28];
        alu_op     <= alu_op_p0;
        mf_op      <= mf_op_p0;
        reg_d      <= inst[15:12];
        s_cpsr     <= s_cpsr_p0;
        dp_dt      <= dp_dt_p0;
        r_i        <= inst[25];
        illegal    <= illegal_p0;
        operand_1  <= op1_p0;
        operand_2  <= op2_p0;
        store_data <= st_p0;
      end
      // R15 is the PC, never a stored register.
      if (wb_en && (wb_addr != 4'd15))
        rf[wb_addr] <= wb_data;
    end
  end

endmodule

// File: doc/decode_read_stage.md
Name: decode_read_stage

Overview:
- Parametrised successor to the single-cycle decode/operand-read front end.
- Decodes ARM data-processing and single-data-transfer instructions and reads up to three operands from an internal 16-entry register file with writeback bypass.
- Delivers decoded fields and operands through one registered pipeline stage with a valid/ready handshake, flush, and illegal-instruction flagging.
- Sits between instruction fetch and the ALU/memory-function stage.

Parameters:
- DATA_W, 32: register/operand width; must be >= 32, immediates are zero-extended above bit 31.
- FWD_EN, 1: 1 = writeback port bypasses to same-cycle register reads; 0 = reads return pre-write contents.
- PC_OFFSET, 8: value added to pc_in when R15 is read as an operand.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  inst/pc_in valid.
- in_ready  out  1  stage can accept; = !out_valid || out_ready (combinational).
- inst  in  32  instruction word.
- pc_in  in  DATA_W  address of inst.
- flush  in  1  discard the held output and any same-cycle capture.
- wb_en  in  1  register write enable.
- wb_addr  in  4  write address.
- wb_data  in  DATA_W  write data.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream accepts.
- cond  out  4  inst[31:28].
- alu_op  out  4  inst[24:21] for DP, else 0.
- mf_op  out  6  inst[25:20] (I,P,U,B,W,L) for DT, else 0.
- reg_d  out  4  inst[15:12].
- s_cpsr  out  1  inst[20] for DP, else 0.
- dp_dt  out  1  0 = data-processing, 1 = data-transfer.
- r_i  out  1  inst[25].
- illegal  out  1  inst[27:26] is 2'b10 or 2'b11.
- operand_1  out  DATA_W  value of Rn (inst[19:16]).
- operand_2  out  DATA_W  immediate or shifted Rm.
- store_data  out  DATA_W  value of Rd (inst[15:12]).

Behaviour:
- Reset (rst_n low, async): out_valid=0; every output bundle field=0; all 16 register-file entries=0. Deassertion is synchronised by the user; the block imposes no further sequencing.
- Capture: when in_valid && in_ready && !flush, all outputs load on the edge. Latency is 1 cycle from inst to out_valid.
- out_valid:
  - Set on capture.
  - Cleared on an edge where out_ready=1 and no capture occurs.
  - Held, with the bundle frozen, while out_ready=0.
- Flush: forces out_valid=0 on the edge, overriding capture. Outputs keep their stale values but are don't-care.
- DP class (inst[27:26]=00):
  - r_i=1: operand_2 = zero-extend(inst[7:0]) rotated right by 2*inst[11:8], computed in 32 bits.
  - r_i=0: operand_2 = Rm (inst[3:0]) LSL inst[11:7] when inst[4]=0 and inst[6:5]=00. Any other shift form → operand_2 = unshifted Rm.
- DT class (inst[27:26]=01):
  - I=0: operand_2 = zero-extend(inst[11:0]).
  - I=1: operand_2 = Rm LSL inst[11:7].
  - alu_op=0, s_cpsr=0.
- Illegal class: captured normally with illegal=1. alu_op, mf_op, s_cpsr, operand_1, operand_2 and store_data are all 0.
- Register reads:
  - Three combinational read ports (Rn, Rm, Rd) sampled at capture.
  - Address 15 returns pc_in + PC_OFFSET (mod 2^DATA_W).
  - If FWD_EN=1 and wb_en=1 and wb_addr equals the read address (not 15), the read returns wb_data.
- Writes: on wb_en at the edge, independent of handshake, stall or flush. Writes to address 15 are ignored.
- Held bundles are not refreshed by later writebacks; hazard ordering is the issuing stage's responsibility.
- Back-to-back: with out_ready=1 held high, one instruction per cycle, no bubbles.

Test Plan:
- Reset then inst=e3a03005, in_valid=1, out_ready=1 → next edge: out_valid=1, dp_dt=0, r_i=1, alu_op=4'hD, reg_d=3, operand_2=32'h5, s_cpsr=0.
- inst=e3a004ff → operand_2=32'hFF000000 (rotate 8); inst=e24dd00c with pc_in=0x100 → alu_op=4'h2, operand_1=R13.
- Write R11=0x1000 via wb port, then inst=e50b3008 → dp_dt=1, mf_op=6'h10, operand_1=0x1000, operand_2=0x8, reg_d=3, store_data=R3.
- Same-cycle write R2=7, R3 preloaded 5, inst=e0823003:
  - FWD_EN=1 → operand_1=7, operand_2=5.
  - FWD_EN=0 → operand_1=old R2.
- out_ready=0 for 3 cycles with a second inst pending → in_ready=0, bundle unchanged. On out_ready=1, the next inst is captured on the following edge. flush during the stall → out_valid=0.
- inst=ea000000 → illegal=1, operands 0. rst_n pulsed low mid-transfer → out_valid=0 immediately (async), register file cleared.
